// File: rtl/data_mem_resp.sv
`default_nettype none
// data_mem_resp: byte-addressable 32-bit data memory with a combinational read port and saturating access counters.
// Macro DMEM_MISALIGN_CHECK_EN: suppress and flag misaligned accesses instead of silently aligning them.
module data_mem_resp #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        R_en,
   input  logic        W_en,
   input  logic [2:0]  RW_type,
   input  logic [31:0] ram_addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [15:0] load_cnt,
   output logic [15:0] store_cnt,
   output logic        err_misalign,
   output logic [31:0] err_addr
);
   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic [31:0]   rd_word;
   logic          rd_type_ok, wr_type_ok, is_half, is_word;
   logic          suppress, rd_acc, wr_acc;
   logic [1:0]    eff_lo;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic [15:0]   load_cnt_q, load_cnt_d, store_cnt_q, store_cnt_d;
   logic          unused_addr;

   assign unused_addr = ^ram_addr[31:AW+2];
   assign idx         = ram_addr[AW+1:2];
   assign rd_word     = mem_q[idx];

   always_comb begin
      rd_type_ok = 1'b0;
      case (RW_type)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: rd_type_ok = 1'b1;
         default:                                rd_type_ok = 1'b0;
      endcase
   end

   assign wr_type_ok = (RW_type[2] == 1'b0) && (RW_type[1:0] != 2'b11);
   assign is_half    = (RW_type[1:0] == 2'b01);
   assign is_word    = (RW_type == 3'b010);

`ifdef DMEM_MISALIGN_CHECK_EN
   logic        misalign, mis_evt;
   logic        err_q, err_d;
   logic [31:0] err_addr_q, err_addr_d;

   assign misalign   = (is_half && ram_addr[0]) || (is_word && (ram_addr[1:0] != 2'b00));
   assign suppress   = misalign;
   assign eff_lo     = ram_addr[1:0];
   assign mis_evt    = misalign && ((R_en && rd_type_ok) || (W_en && wr_type_ok));
   assign err_d      = err_q | mis_evt;
   // Only the first offending address is kept until reset.
   assign err_addr_d = (mis_evt && !err_q) ? ram_addr : err_addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign err_misalign = err_q;
   assign err_addr     = err_addr_q;
`else
   assign suppress     = 1'b0;
   assign eff_lo       = is_word ? 2'b00 : (is_half ? {ram_addr[1], 1'b0} : ram_addr[1:0]);
   assign err_misalign = 1'b0;
   assign err_addr     = '0;
`endif

   assign rd_acc = R_en && rd_type_ok && !suppress;
   assign wr_acc = W_en && wr_type_ok && !suppress;

   always_comb begin
      case (eff_lo)
         2'd0:    byte_sel = rd_word[7:0];
         2'd1:    byte_sel = rd_word[15:8];
         2'd2:    byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel  = eff_lo[1] ? rd_word[31:16] : rd_word[15:0];
      load_data = '0;
      if (rd_acc) begin
         case (RW_type)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = '0;
         endcase
      end
   end

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      case (RW_type[1:0])
         2'b00:   begin be = 4'b0001 << eff_lo; wdata = {4{store_data[7:0]}}; end
         2'b01:   begin be = eff_lo[1] ? 4'b1100 : 4'b0011; wdata = {2{store_data[15:0]}}; end
         2'b10:   begin be = 4'b1111; wdata = store_data; end
         default: begin be = 4'b0000; wdata = store_data; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign load_cnt_d  = (rd_acc && (load_cnt_q != 16'hFFFF))  ? load_cnt_q + 16'd1  : load_cnt_q;
   assign store_cnt_d = (wr_acc && (store_cnt_q != 16'hFFFF)) ? store_cnt_q + 16'd1 : store_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_cnt_q  <= '0;
         store_cnt_q <= '0;
      end else begin
         load_cnt_q  <= load_cnt_d;
         store_cnt_q <= store_cnt_d;
      end
   end

   assign load_cnt  = load_cnt_q;
   assign store_cnt = store_cnt_q;
endmodule
`default_nettype wire
